net_remap_pipe: RTL and testbench



---
 rtl/net_remap_pipe.sv | 96 +++++++++
 tb/tb_net_remap_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_remap_pipe.sv
// Registered bus-remapping stage: each output bit takes an input bit, a constant, or its own
// previous value, selected through a double-buffered (shadow/active) mapping table.
module net_remap_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SEL_W = 5,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic             cfg_commit,
    output logic             cfg_err,
    output logic [15:0]      xfer_cnt
);

    localparam int EXT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] SEL_CONST0 = SEL_W'(IN_W);
    localparam logic [SEL_W-1:0] SEL_HOLD   = SEL_W'(IN_W + 2);
    localparam logic [IDX_W:0]   IDX_LIMIT  = (IDX_W + 1)'(OUT_W);

    logic [SEL_W-1:0] shadow      [OUT_W];
    logic [SEL_W-1:0] active      [OUT_W];
    logic [SEL_W-1:0] shadow_next [OUT_W];
    logic [EXT_W-1:0] in_ext;
    logic [OUT_W-1:0] remap_data;
    logic             wr_ok;
    logic             accept;

    // Handshake: a word moves when valid && ready are both high at a rising edge. The stage
    // can take a new word whenever its output register is empty or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wr_ok    = cfg_we && ({1'b0, cfg_idx} < IDX_LIMIT) && (cfg_sel <= SEL_HOLD);

    // Input word extended with the constant sources so every select code is a plain bit index.
    always_comb begin
        in_ext               = '0;
        in_ext[IN_W-1:0]     = in_data;
        in_ext[IN_W + 1]     = 1'b1;
    end

    // Shadow contents including this cycle's write, so a same-cycle commit picks it up.
    always_comb begin
        for (int j = 0; j < OUT_W; j++) begin
            shadow_next[j] = shadow[j];
            if (wr_ok && (IDX_W'(j) == cfg_idx)) begin
                shadow_next[j] = cfg_sel;
            end
        end
    end

    always_comb begin
        remap_data = '0;
        for (int j = 0; j < OUT_W; j++) begin
            remap_data[j] = (active[j] == SEL_HOLD) ? out_data[j] : in_ext[active[j]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < OUT_W; j++) begin
                shadow[j] <= SEL_CONST0;
                active[j] <= SEL_CONST0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_err   <= 1'b0;
            xfer_cnt  <= 16'd0;
        end else begin
            for (int j = 0; j < OUT_W; j++) begin
                shadow[j] <= shadow_next[j];
                if (cfg_commit) begin
                    active[j] <= shadow_next[j];
                end
            end
            cfg_err <= cfg_we && !wr_ok;
            if (accept) begin
                out_data  <= remap_data;
                out_valid <= 1'b1;
                xfer_cnt  <= xfer_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_net_remap_pipe.sv
// Scoreboard bench for net_remap_pipe: directed scenarios plus randomized traffic checked
// against a table-level reference model.
module tb_net_remap_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int SEL_W = 5;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic             cfg_commit = 1'b0;
    logic             cfg_err;
    logic [15:0]      xfer_cnt;

    net_remap_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SEL_W(SEL_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_commit(cfg_commit),
        .cfg_err(cfg_err), .xfer_cnt(xfer_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] exp_q[$];

    // reference model state
    int               m_shadow[OUT_W];
    int               m_active[OUT_W];
    logic [OUT_W-1:0] m_last;
    int               m_cnt;
    logic             m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < OUT_W; j++) begin
            m_shadow[j] = IN_W;
            m_active[j] = IN_W;
        end
        m_last = '0;
        m_cnt  = 0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [OUT_W-1:0] model_remap(input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < OUT_W; j++) begin
            s = m_active[j];
            if (s < IN_W)           r[j] = ((int'(d) >> s) & 1) != 0;
            else if (s == IN_W)     r[j] = 1'b0;
            else if (s == IN_W + 1) r[j] = 1'b1;
            else                    r[j] = m_last[j];
        end
        return r;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic we,
                        input logic [IDX_W-1:0] idx, input logic [SEL_W-1:0] sel,
                        input logic cm, output logic acc);
        bit ok;
        logic [OUT_W-1:0] e;
        in_valid   = v;
        in_data    = d;
        cfg_we     = we;
        cfg_idx    = idx;
        cfg_sel    = sel;
        cfg_commit = cm;
        @(negedge clk);
        acc = v && in_ready;
        @(posedge clk);
        if (acc) begin
            e = model_remap(d);
            exp_q.push_back(e);
            m_last = e;
            m_cnt++;
        end
        ok    = we && (int'(idx) < OUT_W) && (int'(sel) <= IN_W + 2);
        m_err = we && !ok;
        if (ok) m_shadow[idx] = int'(sel);
        if (cm) begin
            for (int j = 0; j < OUT_W; j++) m_active[j] = m_shadow[j];
        end
        #1;
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        check("cfg_err", cfg_err, m_err);
        check("xfer_cnt", xfer_cnt, m_cnt & 16'hFFFF);
        if (acc) check("latency_out_valid", out_valid, 1);
    endtask

    task automatic cfg_write(input int idx, input int sel);
        logic acc;
        step(1'b0, '0, 1'b1, IDX_W'(idx), SEL_W'(sel), 1'b0, acc);
    endtask

    task automatic commit();
        logic acc;
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, acc);
    endtask

    task automatic send_word(input logic [IN_W-1:0] d);
        logic acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, d, 1'b0, '0, '0, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_word: word %0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < OUT_W; i++) cfg_write(i, i);
        commit();
    endtask

    // monitor / scoreboard
    logic             stall_seen = 1'b0;
    logic [OUT_W-1:0] stall_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_out_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_data: got unexpected word %0h, expected none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // main sequence
    initial begin
        logic acc;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // tables are const0 after reset
        send_word(16'hFFFF);
        drain();

        // identity
        load_identity();
        send_word(16'hA5C3);
        drain();

        // remap with constants and a shared source
        for (int i = 0; i < OUT_W; i++) cfg_write(i, IN_W);
        cfg_write(7, 9);
        cfg_write(8, IN_W + 1);
        cfg_write(0, 9);
        commit();
        send_word(16'h0200);
        send_word(16'hFDFF);
        drain();

        // backpressure: three words with the sink stalled
        load_identity();
        out_ready = 1'b0;
        send_word(16'h1111);
        fork
            begin
                send_word(16'h2222);
                send_word(16'h3333);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_xfer_cnt", xfer_cnt, m_cnt & 16'hFFFF);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // commit timing and shadow isolation
        for (int i = 0; i < OUT_W; i++) cfg_write(i, IN_W);
        send_word(16'h1234);
        step(1'b1, 16'hFFFF, 1'b0, '0, '0, 1'b1, acc);
        check("commit_cycle_accept", acc, 1);
        send_word(16'hFFFF);
        drain();

        // HOLD on bit 3
        load_identity();
        send_word(16'h0008);
        cfg_write(3, IN_W + 2);
        commit();
        for (int k = 0; k < 4; k++) send_word(16'($urandom) & 16'hFFF7);
        drain();
        check("hold_bit3", out_data[3], 1);

        // rejected write leaves the table intact
        cfg_write(15, 31);
        commit();
        send_word(16'h8000);
        drain();

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
                 IDX_W'($urandom_range(0, 15)), SEL_W'($urandom_range(0, 31)),
                 ($urandom_range(0, 7) == 0), acc);
        end
        drain();

        // async reset while a word is pending
        load_identity();
        out_ready = 1'b0;
        send_word(16'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_xfer_cnt", xfer_cnt, 0);
        model_reset();
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(16'hFFFF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
